// File: rtl/mutate_apply.sv
// Mutation engine: turns one parent gene into OFFSPRING children by random bit flips.
// Build option MUTATE_APPLY_ELITE_EN: the first child of each batch is an exact parent copy.
module mutate_apply #(
   parameter int GENE_BIT  = 80,
   parameter int POS_BIT   = 7,
   parameter int OFFSPRING = 16,
   parameter int FLIP_BIT  = 4
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                maskReady,
   input  logic                start,
   input  logic [GENE_BIT-1:0] parentGene,
   input  logic [POS_BIT-1:0]  randomPos,
   input  logic [FLIP_BIT-1:0] flipCount,
   input  logic                childAccept,
   output logic                maskUsed,
   output logic [GENE_BIT-1:0] childGene,
   output logic [FLIP_BIT-1:0] childIndex,
   output logic                childValid,
   output logic                busy,
   output logic                done
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      FLIP,
      EMIT,
      DONE
   } state_t;

   localparam logic [FLIP_BIT-1:0] LAST_IDX =
      FLIP_BIT'(OFFSPRING - 1);

   state_t              state;
   logic [GENE_BIT-1:0] parent_q;
   logic [FLIP_BIT-1:0] flip_cnt_q;
   logic [FLIP_BIT-1:0] flips;
   logic [POS_BIT-1:0]  pos;
   logic [GENE_BIT-1:0] flip_mask;

   // Out-of-range positions fold back into the gene by dividing by 3.
   always_comb begin
      pos = randomPos;
      if (32'(randomPos) >= GENE_BIT)
         pos = randomPos / POS_BIT'(3);
   end

   assign flip_mask = GENE_BIT'(1) << pos;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state      <= IDLE;
         parent_q   <= '0;
         flip_cnt_q <= '0;
         flips      <= '0;
         maskUsed   <= 1'b0;
         childGene  <= '0;
         childIndex <= '0;
         childValid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         maskUsed <= 1'b0;
         done     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && maskReady) begin
                  parent_q   <= parentGene;
                  flip_cnt_q <= flipCount;
                  childIndex <= LAST_IDX;
                  maskUsed   <= 1'b1;
                  busy       <= 1'b1;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               childGene <= parent_q;
               flips     <= '0;
`ifdef MUTATE_APPLY_ELITE_EN
               state <= (childIndex == LAST_IDX) ?
                        EMIT : FLIP;
`else
               state <= FLIP;
`endif
            end
            FLIP: begin
               if (flips < flip_cnt_q) begin
                  childGene <= childGene ^ flip_mask;
                  flips     <= flips + 1'b1;
               end else begin
                  state <= EMIT;
               end
            end
            // First EMIT cycle raises valid; accept is only honoured after that.
            EMIT: begin
               if (!childValid) begin
                  childValid <= 1'b1;
               end else if (childAccept) begin
                  childValid <= 1'b0;
                  if (childIndex == '0) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     childIndex <= childIndex - 1'b1;
                     state      <= LOAD;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
